// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the iterative accumulator/data ALU.
package alu_pkg;

  localparam logic [2:0] OP_PASSA = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_ABS   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_PASSD = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/mul_iter.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, MUL_W cycles per product.
module mul_iter #(
  parameter int MUL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MUL_W-1:0]   multiplicand,
  input  logic [MUL_W-1:0]   multiplier,
  output logic               done,
  output logic [2*MUL_W-1:0] product
);

  localparam int CW = (MUL_W > 1) ? $clog2(MUL_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_W - 1);

  logic               busy_reg;
  logic [CW-1:0]      count_reg;
  logic [2*MUL_W-1:0] mcand_reg;
  logic [MUL_W-1:0]   mplier_reg;
  logic [2*MUL_W-1:0] prod_reg;
  logic [2*MUL_W-1:0] prod_next;

  // The final partial sum is exposed combinationally so the owner can
  // register it on the same edge that retires the last iteration.
  always_comb begin
    prod_next = prod_reg;
    if (mplier_reg[0]) begin
      prod_next = prod_reg + mcand_reg;
    end
  end

  assign done    = busy_reg && (count_reg == LAST);
  assign product = prod_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg   <= 1'b0;
      count_reg  <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      prod_reg   <= '0;
    end else if (start) begin
      busy_reg   <= 1'b1;
      count_reg  <= '0;
      mcand_reg  <= {{MUL_W{1'b0}}, multiplicand};
      mplier_reg <= multiplier;
      prod_reg   <= '0;
    end else if (busy_reg) begin
      prod_reg   <= prod_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + CW'(1);
      if (done) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Accumulator/data ALU with valid/ready input, registered result and flags,
// and a stalling iterative multiply on the lower half-width operands.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] accum,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int MUL_W = WIDTH / 2;

  state_t           state_reg, state_next;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] neg_a;
  logic [WIDTH-1:0] op_result;
  logic             op_carry;
  logic             op_ovf;

  logic             load_next;
  logic [WIDTH-1:0] result_next;
  logic             carry_next;
  logic             ovf_next;

  logic             out_valid_reg;
  logic [WIDTH-1:0] alu_out_reg;
  logic             zero_reg;
  logic             carry_reg;
  logic             overflow_reg;

  assign in_ready  = (state_reg == ST_IDLE) & ~reset;
  assign accept    = in_valid & in_ready;
  assign mul_start = accept && (opcode == OP_MUL);

  mul_iter #(
    .MUL_W(MUL_W)
  ) u_mul (
    .clk          (clk),
    .reset        (reset),
    .start        (mul_start),
    .multiplicand (accum[MUL_W-1:0]),
    .multiplier   (data[MUL_W-1:0]),
    .done         (mul_done),
    .product      (mul_product)
  );

  assign sum_full = {1'b0, accum} + {1'b0, data};
  assign diff     = accum - data;
  assign neg_a    = '0 - accum;

  always_comb begin
    op_result = '0;
    op_carry  = 1'b0;
    op_ovf    = 1'b0;
    case (opcode)
      OP_PASSA: op_result = accum;
      OP_ADD: begin
        op_result = sum_full[WIDTH-1:0];
        op_carry  = sum_full[WIDTH];
        op_ovf    = (accum[WIDTH-1] == data[WIDTH-1]) &&
                    (sum_full[WIDTH-1] != accum[WIDTH-1]);
      end
      OP_SUB: begin
        op_result = diff;
        op_carry  = accum < data;
        op_ovf    = (accum[WIDTH-1] != data[WIDTH-1]) &&
                    (diff[WIDTH-1] != accum[WIDTH-1]);
      end
      OP_AND: op_result = accum & data;
      OP_XOR: op_result = accum ^ data;
      // Negating the most-negative value wraps back to itself; that case
      // is the only one where the negated value still has its sign bit set.
      OP_ABS: begin
        op_result = accum[WIDTH-1] ? neg_a : accum;
        op_ovf    = accum[WIDTH-1] & neg_a[WIDTH-1];
      end
      OP_PASSD: op_result = data;
      default:  op_result = '0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    load_next   = 1'b0;
    result_next = op_result;
    carry_next  = op_carry;
    ovf_next    = op_ovf;
    case (state_reg)
      ST_IDLE: begin
        if (mul_start) begin
          state_next = ST_MUL;
        end else if (accept) begin
          load_next = 1'b1;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_next  = ST_IDLE;
          load_next   = 1'b1;
          result_next = mul_product;
          carry_next  = 1'b0;
          ovf_next    = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      alu_out_reg   <= '0;
      zero_reg      <= 1'b0;
      carry_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= load_next;
      if (load_next) begin
        alu_out_reg  <= result_next;
        zero_reg     <= (result_next == '0);
        carry_reg    <= carry_next;
        overflow_reg <= ovf_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign alu_out   = alu_out_reg;
  assign zero      = zero_reg;
  assign carry     = carry_reg;
  assign overflow  = overflow_reg;

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised successor to the lab ALU: accumulator/data ALU with a valid/ready input handshake, registered result with status flags, and an iterative shift-add multiplier that works on the full lower half-width instead of a fixed 4-bit multiply. Single-cycle ops sustain one result per cycle; MUL stalls the input for WIDTH/2 cycles. Sits between the datapath register file (accum/data sources) and the writeback stage; out_valid marks each new result.

## Interface
- WIDTH, 8: operand/result width; even, ≥4.
- MUL_W, WIDTH/2 (derived, not overridable): multiplier operand width.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; combinational: (state==IDLE) & ~reset.
- opcode  in  3  operation select.
- data  in  WIDTH  operand B.
- accum  in  WIDTH  operand A.
- out_valid  out  1  one-cycle pulse, new result on alu_out/flags.
- alu_out  out  WIDTH  registered result.
- zero  out  1  result == 0.
- carry  out  1  ADD carry-out / SUB borrow.
- overflow  out  1  signed overflow.

## Operation
- Accept on rising edge with in_valid & in_ready; opcode/data/accum sampled only then, ignored otherwise (requester holds while in_ready=0).
- Opcodes (A=accum, B=data), flags not listed are 0:
  - 000 PASSA: A.
  - 001 ADD: A+B mod 2^WIDTH; carry=bit WIDTH; overflow=signs of A,B equal and differ from result.
  - 010 SUB: A−B mod 2^WIDTH; carry=1 iff A<B unsigned; overflow=signs of A,B differ and result sign ≠ A sign.
  - 011 AND: A&B. 100 XOR: A^B.
  - 101 ABS: A two's-complement magnitude; A=most-negative → result A, overflow=1.
  - 110 MUL: A[MUL_W-1:0] × B[MUL_W-1:0] unsigned, full WIDTH-bit product; upper operand bits ignored.
  - 111 PASSD: B.
- zero computed from the result for every op.
- States: IDLE, MUL.
  - IDLE + accepted non-MUL → result/flags registered, out_valid=1 next cycle, stay IDLE.
  - IDLE + accepted MUL → load multiplicand/multiplier, clear product, counter=0, go MUL.
  - MUL: one multiplier bit per cycle (add shifted multiplicand if bit set); after iteration MUL_W−1 write result/flags, out_valid=1, go IDLE.
- alu_out and flags hold the last result until the next out_valid; no output backpressure.

## Timing
- Reset (sync, while high or on edge): state=IDLE, alu_out=0, zero=0, carry=0, overflow=0, out_valid=0, counter/product cleared; in_ready=0 while reset high, 1 on the first cycle after.
- Non-MUL latency: 1 cycle (accept edge N → out_valid high after edge N+1? No: result registered at edge N, out_valid high in cycle N..N+1).
- MUL latency: MUL_W cycles; accept at edge N, in_ready=0 for cycles after edges N..N+MUL_W−1, result and out_valid appear after edge N+MUL_W, in_ready=1 in that same cycle.
- Back-to-back non-MUL ops: out_valid high on consecutive cycles.
- Reset during MUL: operation aborted, no out_valid, outputs to reset values.
- in_valid during MUL: not accepted, no effect.

## Structure
- Package alu_pkg: opcode localparams (OP_PASSA…OP_PASSD), state encoding (ST_IDLE, ST_MUL).
- Sub-module mul_iter (parameter MUL_W): start/operands in, done/product out, counter internal; alu_iter owns handshake, opcode decode, flag logic, output registers.

## Test plan (WIDTH=8)
- AND accum=0x00 data=0xA2 → alu_out=0x00, zero=1, carry=0, overflow=0, out_valid one cycle after accept.
- SUB accum=0x0F data=0x1D → 0xF2, carry=1, overflow=0, zero=0; ADD 0xFF+0x01 → 0x00, carry=1, zero=1; ADD 0x7F+0x01 → 0x80, overflow=1.
- MUL accum=0xFF data=0x1D → 15×13=0xC3; in_ready low exactly 4 cycles, out_valid exactly 4 cycles after accept; in_valid with other opcode held during stall accepted on the cycle in_ready returns.
- ABS accum=0x80 → 0x80, overflow=1; ABS 0xF6 → 0x0A, overflow=0.
- Reset asserted 2 cycles into MUL → no out_valid, alu_out=0, flags 0, in_ready=1 cycle after reset drops.
- Three back-to-back PASSA/PASSD/XOR (accum=0x3C, data=0x5A) → 0x3C, 0x5A, 0x66 on three consecutive out_valid cycles; repeat with WIDTH=16 MUL 0x00FF×0x00FF → 0xFE01 after 8 cycles.
